// File: rtl/sim_ctrl_responder.sv
// Simulation-control responder: TOHOST exit register, console byte FIFO,
// free-running cycle counter and watchdog, behind a one-cycle-latency bus.
module sim_ctrl_responder #(
   parameter int unsigned DEPTH          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [3:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        con_valid,
   input  logic        con_ready,
   output logic [7:0]  con_data,
   output logic        done,
   output logic        pass,
   output logic [30:0] exit_code,
   output logic        timeout
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_t;

   state_t          state, state_next;
   logic [31:0]     tohost;
   logic [31:0]     cycle_cnt;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty;
   logic            accept, push, pop;
   logic            tohost_wr, exit_wr, wd_hit, cnt_en;
   logic [1:0]      sel;
   logic [31:0]     rdata_next;
   logic            unused_addr_bits;

   assign sel              = req_addr[3:2];
   assign unused_addr_bits = ^req_addr[1:0];

   // full derives only from registered count, so a same-cycle pop never admits a push
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign req_ready = !(req_valid && req_we && (sel == 2'd1) && full);
   assign accept    = req_valid && req_ready;
   assign push      = accept && req_we && (sel == 2'd1);
   assign pop       = !empty && con_ready;
   assign con_valid = !empty;
   assign con_data  = empty ? '0 : mem[rd_ptr];

   assign tohost_wr = accept && req_we && (sel == 2'd0) && (state == S_RUN);
   assign exit_wr   = tohost_wr && req_wdata[0];
   assign wd_hit    = (TIMEOUT_CYCLES != 0) && (cycle_cnt == WD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RUN;
      else        state <= state_next;
   end

   // An exit write takes priority over watchdog expiry on the same edge
   always_comb begin
      state_next = state;
      cnt_en     = 1'b0;
      done       = 1'b0;
      timeout    = 1'b0;
      case (state)
         S_RUN: begin
            if (exit_wr)     state_next = S_DONE;
            else if (wd_hit) state_next = S_TIMEOUT;
            else             cnt_en     = 1'b1;
         end
         S_DONE:    done       = 1'b1;
         S_TIMEOUT: timeout    = 1'b1;
         default:   state_next = S_RUN;
      endcase
   end

   always_comb begin
      rdata_next = '0;
      if (!req_we) begin
         case (sel)
            2'd0:    rdata_next = tohost;
            2'd2:    rdata_next = {22'b0, timeout, done, full, empty, 6'(count)};
            2'd3:    rdata_next = cycle_cnt;
            default: rdata_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tohost    <= '0;
         cycle_cnt <= '0;
         pass      <= 1'b0;
         exit_code <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (cnt_en)    cycle_cnt <= cycle_cnt + 32'd1;
         if (tohost_wr) tohost    <= req_wdata;
         if (exit_wr) begin
            exit_code <= req_wdata[31:1];
            pass      <= (req_wdata[31:1] == '0);
         end
         rsp_valid <= accept;
         rsp_rdata <= accept ? rdata_next : '0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= req_wdata[7:0];
   end

endmodule

// File: tb/tb_sim_ctrl_responder.sv
// Bench for sim_ctrl_responder: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_sim_ctrl_responder;

   localparam int DEPTH = 8;
   localparam int TO    = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [3:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        con_valid;
   logic        con_ready = 1'b0;
   logic [7:0]  con_data;
   logic        done, pass, timeout;
   logic [30:0] exit_code;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sim_ctrl_responder #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
      .done(done), .pass(pass), .exit_code(exit_code), .timeout(timeout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: flags, a byte queue and counters
   bit          m_done = 0, m_to = 0, m_pass = 0, m_rsp = 0;
   logic [30:0] m_exit = '0;
   logic [31:0] m_tohost = '0, m_cycle = '0, m_rdata = '0;
   byte unsigned m_q[$];

   function automatic bit m_ready();
      return !(req_valid && req_we && req_addr[3:2] == 2'd1 && m_q.size() == DEPTH);
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit acc, run, pop, exitw, expire;
      int unsigned sz;
      logic [31:0] rd;
      if (!rst_n) begin
         m_done = 0; m_to = 0; m_pass = 0; m_rsp = 0;
         m_exit = '0; m_tohost = '0; m_cycle = '0; m_rdata = '0;
         m_q.delete();
      end else begin
         acc = req_valid && m_ready();
         run = !m_done && !m_to;
         sz  = m_q.size();
         pop = (sz > 0) && con_ready;
         rd  = '0;
         if (acc && !req_we) begin
            case (req_addr[3:2])
               2'd0: rd = m_tohost;
               2'd2: rd = 32'(m_to) * 512 + 32'(m_done) * 256 + 32'(sz == DEPTH) * 128
                          + 32'(sz == 0) * 64 + sz;
               2'd3: rd = m_cycle;
               default: rd = '0;
            endcase
         end
         m_rsp   = acc;
         m_rdata = rd;
         exitw   = run && acc && req_we && req_addr[3:2] == 2'd0 && req_wdata[0];
         expire  = run && (m_cycle == TO - 1);
         if (run && acc && req_we && req_addr[3:2] == 2'd0) m_tohost = req_wdata;
         if (exitw) begin
            m_done = 1;
            m_exit = req_wdata[31:1];
            m_pass = (req_wdata[31:1] == 0);
         end else if (expire) begin
            m_to = 1;
         end
         if (!m_done && !m_to) m_cycle = m_cycle + 1;
         if (pop) void'(m_q.pop_front());
         if (acc && req_we && req_addr[3:2] == 2'd1) m_q.push_back(req_wdata[7:0]);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_ready", req_ready, m_ready());
         chk("rsp_valid", rsp_valid, m_rsp);
         if (m_rsp) chk("rsp_rdata", rsp_rdata, m_rdata);
         chk("con_valid", con_valid, m_q.size() > 0);
         if (m_q.size() > 0) chk("con_data", con_data, m_q[0]);
         chk("done", done, m_done);
         chk("timeout", timeout, m_to);
         if (m_done) chk("pass", pass, m_pass);
         chk("exit_code", exit_code, m_exit);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic bus(input bit we, input logic [3:0] addr, input logic [31:0] wd);
      bit r;
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      do begin
         @(negedge clk); r = req_ready;
         @(posedge clk); n++;
      end while (!r && n < 64);
      #1;
      req_valid = 1'b0; req_we = 1'b0;
      if (!r) begin
         checks++; failures++;
         $display("FAIL bus_accept: got no accept expected accept within 64 cycles");
      end
   endtask

   task automatic rd(input logic [3:0] addr, output logic [31:0] d);
      bus(1'b0, addr, '0);
      d = rsp_rdata;
   endtask

   task automatic collect(input int n, input int first);
      int got, cyc;
      got = 0; cyc = 0;
      while (got < n && cyc < 100) begin
         @(negedge clk);
         if (con_valid && con_ready) begin
            chk("con_order", con_data, first + got);
            got++;
         end
         cyc++;
      end
      if (got < n) begin
         checks++; failures++;
         $display("FAIL con_collect: got %0d bytes expected %0d", got, n);
      end
   endtask

   task automatic do_reset();
      req_valid = 1'b0; req_we = 1'b0; con_ready = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_con_valid", con_valid, 0);
      chk("rst_con_data", con_data, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_exit", exit_code, 0);
      chk("rst_timeout", timeout, 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [31:0] d, c;
      int n;
      #1;
      // Passing exit, later exit write ignored
      do_reset();
      bus(1'b1, 4'h0, 32'h1);
      chk("exit1_done", done, 1);
      chk("exit1_pass", pass, 1);
      chk("exit1_code", exit_code, 0);
      chk("exit1_rsp", rsp_valid, 1);
      chk("exit1_rdata", rsp_rdata, 0);
      bus(1'b1, 4'h0, 32'h7);
      chk("exit1_code_kept", exit_code, 0);
      chk("exit1_pass_kept", pass, 1);
      rd(4'h0, d);
      chk("tohost_kept", d, 32'h1);

      // Failing exit, frozen cycle counter
      do_reset();
      bus(1'b1, 4'h0, 32'h7);
      chk("exit7_done", done, 1);
      chk("exit7_pass", pass, 0);
      chk("exit7_code", exit_code, 3);
      rd(4'h0, d);
      chk("tohost_read", d, 32'h7);
      rd(4'hC, d);
      rd(4'hC, c);
      chk("cycle_frozen_a", d, 1);
      chk("cycle_frozen_b", c, 1);

      // Fill the console FIFO, then drain with the 9th write pending
      do_reset();
      for (int i = 0; i < 8; i++) bus(1'b1, 4'h4, 32'h41 + i);
      rd(4'h8, d);
      chk("status_full", d, 32'h88);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h4; req_wdata = 32'h49;
      #1;
      chk("ready_low_full", req_ready, 0);
      fork
         bus(1'b1, 4'h4, 32'h49);
         begin con_ready = 1'b1; collect(9, 8'h41); end
      join
      tick();
      con_ready = 1'b0;

      // Streaming push/pop across pointer wrap
      do_reset();
      con_ready = 1'b1;
      fork
         for (int i = 0; i < 20; i++) bus(1'b1, 4'h4, 32'h30 + i);
         collect(20, 8'h30);
      join
      tick();
      con_ready = 1'b0;
      rd(4'h8, d);
      chk("status_empty", d, 32'h40);

      // Watchdog expiry
      do_reset();
      n = 0;
      while (!timeout && n < 100) begin tick(); n++; end
      chk("timeout_edge", n, 49);
      chk("timeout_set", timeout, 1);
      chk("timeout_done", done, 0);
      rd(4'hC, d);
      chk("timeout_cycle", d, 49);
      rd(4'h8, d);
      chk("timeout_status", d, 32'h240);

      // Exit write on the expiry edge wins
      do_reset();
      repeat (48) tick();
      bus(1'b1, 4'h0, 32'h1);
      chk("race_done", done, 1);
      chk("race_timeout", timeout, 0);
      repeat (3) tick();
      chk("race_timeout_later", timeout, 0);
      rd(4'hC, d);
      chk("race_cycle", d, 49);

      // Asynchronous reset with queued bytes and a response in flight
      do_reset();
      for (int i = 0; i < 3; i++) bus(1'b1, 4'h4, 32'h61 + i);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h8;
      tick();
      req_valid = 1'b0;
      chk("inflight_rsp", rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_con_valid", con_valid, 0);
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_con_data", con_data, 0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'hC;
      tick();
      req_valid = 1'b0;
      chk("restart_rsp", rsp_valid, 1);
      chk("restart_cycle", rsp_rdata, 0);
      rd(4'h8, d);
      chk("restart_status", d, 32'h40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench time limit");
   end

endmodule
